// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: sub-word loads/stores with byte enables,
// alignment rejection, BEQ/BNE resolution and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 5,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_BITS  = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_branch,
  input  logic                  i_branchNe,
  input  logic                  i_ceroSignal,
  input  logic [N_BITS-1:0]     i_branchTarget,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic [1:0]            i_memSize,
  input  logic                  i_memUnsigned,
  input  logic                  i_memToReg,
  input  logic                  i_regWrite,
  input  logic [N_BITS-1:0]     i_aluResult,
  input  logic [N_BITS-1:0]     i_datoLeido2,
  input  logic [N_BITS_REG-1:0] i_rt_OR_rd,
  input  logic [ADDR_BITS-1:0]  i_dbgAddr,
  output logic                  o_pcSource,
  output logic [N_BITS-1:0]     o_pcBranch,
  output logic                  o_memToReg_MEM_WB,
  output logic                  o_regWrite_MEM_WB,
  output logic [N_BITS-1:0]     o_readData,
  output logic [N_BITS-1:0]     o_aluResult,
  output logic [N_BITS_REG-1:0] o_rt_OR_rd,
  output logic                  o_misaligned,
  output logic [N_BITS-1:0]     o_dbgData
);

  logic [N_BITS-1:0]    mem [MEM_DEPTH];
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic                 is_half;
  logic                 is_word;
  logic                 misaligned;
  logic                 write_en;
  logic [3:0]           byte_en;
  logic [N_BITS-1:0]    write_data;
  logic [N_BITS-1:0]    read_word;
  logic [7:0]           sel_byte;
  logic [15:0]          sel_half;
  logic [N_BITS-1:0]    load_data;
  logic                 unused_addr_bits;

  assign o_pcSource = (i_branch & i_ceroSignal) | (i_branchNe & ~i_ceroSignal);
  assign o_pcBranch = i_branchTarget;
  assign o_dbgData  = mem[i_dbgAddr];

  // Address bits above the word index are ignored so accesses wrap modulo MEM_DEPTH.
  assign unused_addr_bits = ^i_aluResult[N_BITS-1:ADDR_BITS+2];
  assign word_idx = i_aluResult[ADDR_BITS+1:2];
  assign lane     = i_aluResult[1:0];

  always_comb begin
    is_half    = (i_memSize == 2'b01);
    is_word    = i_memSize[1];
    misaligned = (i_memRead | i_memWrite) &
                 ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
    write_en   = i_valid & ~i_reset & i_memWrite & ~misaligned;

    // Store data is replicated across lanes; byte enables pick the target lanes.
    byte_en    = 4'b0001 << lane;
    write_data = {4{i_datoLeido2[7:0]}};
    if (is_word) begin
      byte_en    = 4'b1111;
      write_data = i_datoLeido2;
    end else if (is_half) begin
      byte_en    = lane[1] ? 4'b1100 : 4'b0011;
      write_data = {2{i_datoLeido2[15:0]}};
    end

    // Read sees pre-write contents; the write lands at the clock edge.
    read_word = mem[word_idx];
    sel_byte  = read_word[{lane, 3'b000} +: 8];
    sel_half  = lane[1] ? read_word[31:16] : read_word[15:0];
    if (is_word)
      load_data = read_word;
    else if (is_half)
      load_data = {{(N_BITS-16){~i_memUnsigned & sel_half[15]}}, sel_half};
    else
      load_data = {{(N_BITS-8){~i_memUnsigned & sel_byte[7]}}, sel_byte};
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (write_en && byte_en[k])
        mem[word_idx][8*k +: 8] <= write_data[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_memToReg_MEM_WB <= 1'b0;
      o_regWrite_MEM_WB <= 1'b0;
      o_readData        <= '0;
      o_aluResult       <= '0;
      o_rt_OR_rd        <= '0;
      o_misaligned      <= 1'b0;
    end else if (i_valid) begin
      o_memToReg_MEM_WB <= i_memToReg;
      o_regWrite_MEM_WB <= i_regWrite & ~misaligned;
      o_readData        <= (i_memRead && !misaligned) ? load_data : '0;
      o_aluResult       <= i_aluResult;
      o_rt_OR_rd        <= i_rt_OR_rd;
      o_misaligned      <= misaligned;
    end
  end

endmodule
